multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ALUsource_pkg.sv | 9 +
 rtl/control_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ALUsource_pkg.sv
// ALU B-operand source selection shared by control and datapath.
package ALUsource_pkg;

  typedef enum logic {
    ALU_RD2    = 1'b0,
    ALU_EXTEND = 1'b1
  } alu_src_t;

endpackage

// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle controller.
package control_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned OP_W       = 7;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXEC_R,
    EXEC_I,
    ALUWB,
    BRANCH,
    JAL
  } state_t;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_t;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1001;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALU operation class plus funct fields to an ALU control code.
module alu_decoder
  import control_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_ctrl
);

  // funct3 decode; funct7b5 picks SUB for R-type only, SRA for both
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_ctrl = ALU_ADD;
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      default: begin
        case (i_funct3)
          3'b000:  o_alu_ctrl = (i_alu_op == ALUOP_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_ctrl = ALU_SLL;
          3'b010:  o_alu_ctrl = ALU_SLT;
          3'b011:  o_alu_ctrl = ALU_SLTU;
          3'b100:  o_alu_ctrl = ALU_XOR;
          3'b101:  o_alu_ctrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style controller: Moore FSM plus retired-instruction counter.
module multicycle_control
  import control_pkg::*;
  import ALUsource_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        adr_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  imm_src,
  output logic        alu_src,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic [31:0] instr_count
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_retire;
  logic [1:0]         w_alu_op;
  logic [CNT_W-1:0]   r_instr_count;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_next;
  end

  // Next-state logic; w_retire marks a completed instruction returning to FETCH
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    case (r_state)
      FETCH:    if (mem_ready) w_state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_state_next = MEMADR;
          OP_R:              w_state_next = EXEC_R;
          OP_I:              w_state_next = EXEC_I;
          OP_BRANCH:         w_state_next = BRANCH;
          OP_JAL:            w_state_next = JAL;
          default:           w_state_next = FETCH;
        endcase
      end
      MEMADR:   w_state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) w_state_next = MEMWB;
      MEMWRITE: begin
        if (mem_ready) begin
          w_state_next = FETCH;
          w_retire     = 1'b1;
        end
      end
      EXEC_R:   w_state_next = ALUWB;
      EXEC_I:   w_state_next = ALUWB;
      MEMWB, ALUWB, BRANCH, JAL: begin
        w_state_next = FETCH;
        w_retire     = 1'b1;
      end
      default:  w_state_next = FETCH;
    endcase
  end

  // Moore outputs of the state; FETCH handshake and branch decision use live inputs
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = ALU_RD2;
    result_src = RES_ALU;
    illegal    = 1'b0;
    w_alu_op   = ALUOP_ADD;
    case (r_state)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src = ALU_EXTEND;
        imm_src = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
      end
      EXEC_R: begin
        alu_src  = ALU_RD2;
        w_alu_op = ALUOP_R;
      end
      EXEC_I: begin
        alu_src  = ALU_EXTEND;
        imm_src  = IMM_I;
        w_alu_op = ALUOP_I;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALU;
      end
      BRANCH: begin
        alu_src  = ALU_RD2;
        imm_src  = IMM_B;
        pc_src   = 1'b1;
        w_alu_op = ALUOP_SUB;
        if (funct3 == F3_BEQ)      pc_write = zero;
        else if (funct3 == F3_BNE) pc_write = ~zero;
      end
      JAL: begin
        imm_src    = IMM_J;
        pc_src     = 1'b1;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
      end
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)           r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  assign instr_count = r_instr_count;

  alu_decoder u_alu_decoder (
    .i_alu_op   (w_alu_op),
    .i_funct3   (funct3),
    .i_funct7b5 (funct7b5),
    .o_alu_ctrl (alu_ctrl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_src, adr_src, ir_write, mem_read, mem_write, reg_write;
  logic [1:0]  imm_src;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic [1:0]  result_src;
  logic        illegal;
  logic [31:0] instr_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [16:0] w_obs;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .imm_src     (imm_src),
    .alu_src     (alu_src),
    .alu_ctrl    (alu_ctrl),
    .result_src  (result_src),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  assign w_obs = {pc_write, pc_src, adr_src, ir_write, mem_read, mem_write, reg_write,
                  imm_src, alu_src, alu_ctrl, result_src, illegal};

  // Expected output vector in the same order as w_obs
  function automatic logic [16:0] mk(input logic pcw, input logic pcs, input logic adr,
                                     input logic irw, input logic mr, input logic mw,
                                     input logic rw, input logic [1:0] imm, input logic asrc,
                                     input logic [3:0] ac, input logic [1:0] rs,
                                     input logic ill);
    return {pcw, pcs, adr, irw, mr, mw, rw, imm, asrc, ac, rs, ill};
  endfunction

  localparam logic [16:0] V_FW    = mk(0,0,0,0,1,0,0,2'b00,0,4'b0000,2'b00,0);
  localparam logic [16:0] V_FG    = mk(1,0,0,1,1,0,0,2'b00,0,4'b0000,2'b00,0);
  localparam logic [16:0] V_ZERO  = mk(0,0,0,0,0,0,0,2'b00,0,4'b0000,2'b00,0);
  localparam logic [16:0] V_ILL   = mk(0,0,0,0,0,0,0,2'b00,0,4'b0000,2'b00,1);
  localparam logic [16:0] V_ALUWB = mk(0,0,0,0,0,0,1,2'b00,0,4'b0000,2'b00,0);
  localparam logic [16:0] V_RSUB  = mk(0,0,0,0,0,0,0,2'b00,0,4'b0001,2'b00,0);
  localparam logic [16:0] V_RXOR  = mk(0,0,0,0,0,0,0,2'b00,0,4'b0100,2'b00,0);
  localparam logic [16:0] V_IADD  = mk(0,0,0,0,0,0,0,2'b00,1,4'b0000,2'b00,0);
  localparam logic [16:0] V_ISRA  = mk(0,0,0,0,0,0,0,2'b00,1,4'b1001,2'b00,0);
  localparam logic [16:0] V_ISRL  = mk(0,0,0,0,0,0,0,2'b00,1,4'b1000,2'b00,0);
  localparam logic [16:0] V_MAS   = mk(0,0,0,0,0,0,0,2'b01,1,4'b0000,2'b00,0);
  localparam logic [16:0] V_MR    = mk(0,0,1,0,1,0,0,2'b00,0,4'b0000,2'b00,0);
  localparam logic [16:0] V_MWB   = mk(0,0,0,0,0,0,1,2'b00,0,4'b0000,2'b01,0);
  localparam logic [16:0] V_MW    = mk(0,0,1,0,0,1,0,2'b00,0,4'b0000,2'b00,0);
  localparam logic [16:0] V_BRT   = mk(1,1,0,0,0,0,0,2'b10,0,4'b0001,2'b00,0);
  localparam logic [16:0] V_BRN   = mk(0,1,0,0,0,0,0,2'b10,0,4'b0001,2'b00,0);
  localparam logic [16:0] V_JAL   = mk(1,1,0,0,0,0,1,2'b11,0,4'b0000,2'b10,0);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_o(input string tag, input logic [16:0] exp);
    #1;
    n_cmp++;
    assert (w_obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, w_obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [31:0] exp);
    #1;
    n_cmp++;
    assert (instr_count === exp) else begin
      n_fail++;
      $error("FAIL %s: observed count %0d expected %0d", tag, instr_count, exp);
    end
  endtask

  // From FETCH (at negedge): load instruction fields, pass FETCH and DECODE
  task automatic fetch_decode(input string tag, input logic [6:0] o, input logic [2:0] f3,
                              input logic f7);
    op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
    chk_o({tag, "_fetch"}, V_FG);
    tick();
    chk_o({tag, "_decode"}, V_ZERO);
    tick();
  endtask

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();

    // Reset state: FETCH waiting on memory
    chk_o("reset_fetch_wait", V_FW);
    chk_c("reset_count", 32'd0);
    rst = 1'b0;

    // add
    fetch_decode("add", 7'b0110011, 3'b000, 1'b0);
    chk_o("add_exec_r", V_ZERO);
    tick();
    chk_o("add_aluwb", V_ALUWB);
    chk_c("add_count_before", 32'd0);
    tick();
    chk_c("add_count_after", 32'd1);

    // sub
    fetch_decode("sub", 7'b0110011, 3'b000, 1'b1);
    chk_o("sub_exec_r", V_RSUB);
    tick(); tick();

    // xor
    fetch_decode("xor", 7'b0110011, 3'b100, 1'b0);
    chk_o("xor_exec_r", V_RXOR);
    tick(); tick();

    // addi with funct7b5 set must stay ADD
    fetch_decode("addi", 7'b0010011, 3'b000, 1'b1);
    chk_o("addi_exec_i", V_IADD);
    tick();
    chk_o("addi_aluwb", V_ALUWB);
    tick();

    // srai
    fetch_decode("srai", 7'b0010011, 3'b101, 1'b1);
    chk_o("srai_exec_i", V_ISRA);
    tick(); tick();

    // srli
    fetch_decode("srli", 7'b0010011, 3'b101, 1'b0);
    chk_o("srli_exec_i", V_ISRL);
    tick(); tick();
    chk_c("alu_count", 32'd6);

    // lw with three stall cycles in MEMREAD
    fetch_decode("lw", 7'b0000011, 3'b010, 1'b0);
    chk_o("lw_memadr", V_IADD);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_o("lw_memread_stall", V_MR);
      tick();
    end
    mem_ready = 1'b1;
    chk_o("lw_memread_done", V_MR);
    tick();
    chk_o("lw_memwb", V_MWB);
    tick();
    chk_c("lw_count", 32'd7);

    // sw with one stall cycle
    fetch_decode("sw", 7'b0100011, 3'b010, 1'b0);
    chk_o("sw_memadr", V_MAS);
    mem_ready = 1'b0;
    tick();
    chk_o("sw_memwrite_stall", V_MW);
    chk_c("sw_count_stall", 32'd7);
    tick();
    mem_ready = 1'b1;
    chk_o("sw_memwrite_done", V_MW);
    tick();
    chk_c("sw_count", 32'd8);

    // beq taken
    fetch_decode("beq_t", 7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    chk_o("beq_taken", V_BRT);
    tick();
    // beq not taken
    fetch_decode("beq_n", 7'b1100011, 3'b000, 1'b0);
    zero = 1'b0;
    chk_o("beq_not_taken", V_BRN);
    tick();
    // bne taken
    fetch_decode("bne_t", 7'b1100011, 3'b001, 1'b0);
    zero = 1'b0;
    chk_o("bne_taken", V_BRT);
    tick();
    chk_c("branch_count", 32'd11);

    // jal
    fetch_decode("jal", 7'b1101111, 3'b000, 1'b0);
    chk_o("jal", V_JAL);
    tick();
    chk_c("jal_count", 32'd12);

    // illegal opcode: one DECODE cycle with illegal, back to FETCH, no count
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    tick();
    chk_o("illegal_decode", V_ILL);
    tick();
    chk_o("illegal_back_fetch", V_FG);
    chk_c("illegal_count", 32'd12);

    // reset in the middle of a stalled MEMWRITE
    fetch_decode("sw_rst", 7'b0100011, 3'b010, 1'b0);
    mem_ready = 1'b0;
    tick();
    chk_o("rst_memwrite", V_MW);
    rst = 1'b1;
    tick();
    chk_o("rst_to_fetch", V_FW);
    chk_c("rst_count", 32'd0);
    rst = 1'b0;
    tick();
    chk_o("rst_release_fetch", V_FW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
